serial_subtractor: RTL and testbench

Bit-serial unsigned subtractor computing d = a − b one bit per clock, LSB first, through a single full-subtractor cell and a borrow flip-flop. It is the inverse-direction companion to the lab's combinational adder blocks. It is a small sequential datapath with a start/done handshake, intended to be driven by a lab testbench or an upstream controller.

---
 rtl/serial_subtractor_pkg.sv | 17 +
 rtl/serial_subtractor_full_subtractor.sv | 19 +
 rtl/serial_subtractor.sv | 132 +++++++++++++
 tb/tb_serial_subtractor.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
//   state_e   : FSM state encoding (IDLE=0, RUN=1, DONE=2; 3 is unused)
//   cnt_width : bit counter width able to hold 0..width without wrapping
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // ceil(log2(width+1)) so the counter can represent the full bit count
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit combinational full subtractor: diff = x - y - bin.
//   x, y : operand bits
//   bin  : borrow in
//   diff : difference bit
//   bout : borrow out
module serial_subtractor_full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic diff,
    output logic bout
);

    always_comb begin
        diff = x ^ y ^ bin;
        bout = (~x & y) | (~(x ^ y) & bin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, d = a - b, LSB first, one bit per clock.
//   clk, rst : clock, synchronous active-high reset
//   start    : request, sampled in IDLE and DONE only
//   a, b     : minuend / subtrahend, captured on accepted start
//   busy     : high while bits are being processed (RUN)
//   done     : one-cycle pulse when d/bout are updated
//   d        : difference modulo 2^WIDTH, held until the next completion
//   bout     : final borrow, 1 iff a < b
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    // Holds the first WIDTH-1 difference bits; the last bit joins on the way to d
    logic [WIDTH-2:0]   res_q, res_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               brw_q, brw_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   d_q, d_d;
    logic               bout_q, bout_d;

    logic               cell_diff;
    logic               cell_bout;
    logic [WIDTH-1:0]   res_cat;

    serial_subtractor_full_subtractor u_full_subtractor (
        .x    (a_q[0]),
        .y    (b_q[0]),
        .bin  (brw_q),
        .diff (cell_diff),
        .bout (cell_bout)
    );

    // Current bit shifted in from the MSB side above the partial result
    assign res_cat = {cell_diff, res_q};

    // Next-state and datapath control
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        brw_d   = brw_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        d_d     = d_q;
        bout_d  = bout_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start) begin
                    state_d = ST_RUN;
                    busy_d  = 1'b1;
                    a_d     = a;
                    b_d     = b;
                    res_d   = '0;
                    cnt_d   = '0;
                    brw_d   = 1'b0;
                end
            end
            ST_RUN: begin
                busy_d = 1'b1;
                a_d    = a_q >> 1;
                b_d    = b_q >> 1;
                res_d  = res_cat[WIDTH-1:1];
                brw_d  = cell_bout;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    d_d     = res_cat;
                    bout_d  = cell_bout;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            brw_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            d_q     <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            brw_q   <= brw_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            d_q     <= d_d;
            bout_q  <= bout_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign d    = d_q;
    assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): directed cases plus
// random operand pairs compared against plain unsigned arithmetic.
module tb_serial_subtractor;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned LAT   = WIDTH + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             bout;

    int n_checks = 0;
    int n_err    = 0;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .d     (d),
        .bout  (bout)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle before sampling/driving
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: unsigned subtraction modulo 2^WIDTH and borrow as a < b
    function automatic logic [WIDTH:0] ref_sub(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        int unsigned diff;
        diff = (int'(x) - int'(y) + (1 << WIDTH)) % (1 << WIDTH);
        return {x < y, WIDTH'(diff)};
    endfunction

    // Pulse start for one cycle, then wait for done; returns the cycle count
    // from the start cycle and how many of those cycles had busy high.
    task automatic launch_and_wait(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                                   output int lat, output int busy_cyc);
        start = 1'b1;
        a     = ta;
        b     = tb_;
        tick();
        start    = 1'b0;
        lat      = 1;
        busy_cyc = 0;
        while (!done && lat < 40) begin
            if (busy) busy_cyc++;
            tick();
            lat++;
        end
        if (!done) begin
            n_checks++;
            n_err++;
            $error("FAIL timeout observed=no_done expected=done");
        end
    endtask

    initial begin
        int lat;
        int bc;
        int done_seen;
        logic [WIDTH:0] exp;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_d",    32'(d),    32'd0);
        check("rst_bout", 32'(bout), 32'd0);
        rst = 1'b0;
        tick();

        // Basic: 0x5A - 0x23
        launch_and_wait(8'h5A, 8'h23, lat, bc);
        check("t1_lat",  32'(lat),  32'(LAT));
        check("t1_busy", 32'(bc),   32'(WIDTH));
        check("t1_d",    32'(d),    32'h37);
        check("t1_bout", 32'(bout), 32'd0);
        check("t1_busy_in_done", 32'(busy), 32'd0);
        tick();
        check("t1_done_pulse", 32'(done), 32'd0);
        check("t1_d_hold",     32'(d),    32'h37);

        // Boundaries: wrap with borrow, equal operands
        launch_and_wait(8'h00, 8'h01, lat, bc);
        check("t2_d",    32'(d),    32'hFF);
        check("t2_bout", 32'(bout), 32'd1);
        tick();
        launch_and_wait(8'hFF, 8'hFF, lat, bc);
        check("t3_d",    32'(d),    32'h00);
        check("t3_bout", 32'(bout), 32'd0);
        tick();

        // Start during RUN is ignored
        start = 1'b1;
        a     = 8'h10;
        b     = 8'h01;
        tick();
        start = 1'b0;
        tick();
        tick();
        start = 1'b1;
        a     = 8'h00;
        b     = 8'h00;
        tick();
        start = 1'b0;
        lat   = 4;
        while (!done && lat < 40) begin
            tick();
            lat++;
        end
        check("t4_lat",  32'(lat),  32'(LAT));
        check("t4_d",    32'(d),    32'h0F);
        check("t4_bout", 32'(bout), 32'd0);

        // Back-to-back start in the DONE cycle
        start = 1'b1;
        a     = 8'h80;
        b     = 8'h7F;
        tick();
        start = 1'b0;
        check("t5_busy_next", 32'(busy), 32'd1);
        check("t5_done_next", 32'(done), 32'd0);
        tick();
        tick();
        tick();
        check("t5_d_hold_mid", 32'(d), 32'h0F);
        lat = 4;
        while (!done && lat < 40) begin
            tick();
            lat++;
        end
        check("t5_lat",  32'(lat),  32'(LAT));
        check("t5_d",    32'(d),    32'h01);
        check("t5_bout", 32'(bout), 32'd0);
        tick();

        // Reset mid-RUN aborts without a done pulse
        start = 1'b1;
        a     = 8'h33;
        b     = 8'h44;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_done", 32'(done), 32'd0);
        check("t6_d",    32'(d),    32'd0);
        check("t6_bout", 32'(bout), 32'd0);
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) done_seen++;
            tick();
        end
        check("t6_no_done", 32'(done_seen), 32'd0);
        launch_and_wait(8'h33, 8'h44, lat, bc);
        exp = ref_sub(8'h33, 8'h44);
        check("t6_after_lat", 32'(lat), 32'(LAT));
        check("t6_after_res", 32'({bout, d}), 32'(exp));

        // Randomized operands, sometimes back-to-back, sometimes with idle gaps
        for (int n = 0; n < 200; n++) begin
            ra  = WIDTH'($urandom);
            rb  = WIDTH'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                for (int g = 0; g < int'($urandom_range(1, 3)); g++) tick();
            end
            exp = ref_sub(ra, rb);
            launch_and_wait(ra, rb, lat, bc);
            check("rand_lat", 32'(lat), 32'(LAT));
            check("rand_res", 32'({bout, d}), 32'(exp));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
